pipelined_register_file: RTL and testbench
==========================================

Name: pipelined_register_file

Overview:
Parametrised successor of the single-cycle register file, for the pipelined IITB-RISC core. Holds NUM_REGS general registers, one of which is the PC, plus C/Z flags. Adds NUM_RD read ports, two prioritised write ports, write-through bypass, and a per-register/per-flag busy scoreboard that drives decode-stage stall.

Parameters:
DATA_W, 16, register and data width
NUM_REGS, 8, number of architectural registers (power of two, >=2)
ADDR_W, $clog2(NUM_REGS), register index width
NUM_RD, 2, number of read ports (1..4)
PC_IDX, 7, register index that doubles as PC
PC_STEP, 1, PC increment on pc_inc

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data
rd_busy  out  NUM_RD  port k addresses a register with an outstanding claim
wa_en  in  1  write port A (ALU writeback) enable
wa_addr  in  ADDR_W  port A destination
wa_data  in  DATA_W  port A data
wb_en  in  1  write port B (load writeback) enable
wb_addr  in  ADDR_W  port B destination
wb_data  in  DATA_W  port B data
claim_en  in  1  issue stage reserves a destination
claim_addr  in  ADDR_W  register to mark busy
claim_c, claim_z  in  1 each  reserve C / Z flag
c_we, z_we  in  1 each  flag write enables
c_data, z_data  in  1 each  flag write values
c_flag, z_flag  out  1 each  current flags (bypassed)
c_busy, z_busy  out  1 each  flag has an outstanding claim
pc_en  in  1  load pc_new into PC
pc_new  in  DATA_W  next PC
pc_inc  in  1  PC += PC_STEP
pc_current  out  DATA_W  registered PC value (not bypassed)
stall  out  1  OR of all rd_busy bits

Behaviour:
- Reset (rst async): all registers, PC, c_flag, z_flag, all busy bits clear to 0. The reset is effective immediately. Any mid-flight claims are discarded.
- Write collision: when wa_en and wb_en target the same address in the same cycle, port B wins. Different addresses both commit on the clock edge.
- PC register update priority, highest first: GPR write to PC_IDX (port B, then A); pc_en loads pc_new; pc_inc adds PC_STEP mod 2^DATA_W (wraps 0xFFFF -> 0x0000 at 16 bit); otherwise hold.
- Reads are combinational. Each read port returns bypassed data in this order: port B data if wb_en and the address matches; else port A data if wa_en and the address matches; else the array content.
- Read of PC_IDX also bypasses a same-cycle GPR write but not pc_en/pc_inc.
- Flags: c_we/z_we update on clk. c_flag/z_flag outputs bypass c_data/z_data when the corresponding we is high.
- Scoreboard, one busy bit per register plus C and Z:
  - Set at the clk edge by claim_en / claim_c / claim_z.
  - Cleared at the edge by a write (either port) to that register, or by c_we / z_we.
  - Simultaneous claim and clear of the same bit: the bit ends set (new claim wins).
- rd_busy[k] = busy[rd_addr[k]] & ~(bypassing write to that address this cycle). This lets a same-cycle writeback resolve the hazard with zero stall.
- c_busy and z_busy are masked the same way by c_we / z_we.
- Latency: write visible to reads in the same cycle via bypass and from the array the next cycle. A claim is visible as busy the cycle after claim_en.
- No read-port or write-port limit on register 0; all registers are writable, including PC_IDX.

Decomposition:
- Shared package rf_pkg holds DATA_W/NUM_REGS defaults, PC_IDX, PC_STEP, and the flag index constants FLAG_C=0, FLAG_Z=1.
- One sub-module, rf_scoreboard: busy-bit vector with set/clear ports and masked lookup. It is instantiated once for NUM_REGS bits and once for 2 flag bits.
- Read-port bypass muxes are generated inline with a for-generate over NUM_RD.

Test Plan:
- Reset then read all: assert rst mid-run after writes -> every rd_data=0, pc_current=0, flags 0, stall=0, no clk needed.
- Dual-write collision: wa_en=wb_en=1, addr 3, wa_data=0x1111, wb_data=0x2222 -> same-cycle rd of r3 = 0x2222; next cycle array r3 = 0x2222.
- Hazard/bypass: claim_en addr 2 at cycle 0 -> cycle 1 read r2 gives rd_busy=1, stall=1. Cycle 2: wa_en addr 2 data 0x00AB -> rd_busy=0, rd_data=0x00AB. Cycle 3: busy clear.
- Claim-vs-clear race: same cycle claim_en addr 5 and wb_en addr 5 -> r5 written, busy[5] still 1 next cycle.
- PC priority: pc=0xFFFF, pc_inc=1 -> 0x0000. Then pc_en=1 pc_new=0x0040 with wa_en addr 7 data 0x0100 -> pc_current=0x0100. Then pc_en alone -> 0x0040.
- Flags: claim_c, then c_we=1 c_data=1 -> c_flag=1 same cycle, c_busy=0. Next cycle c_flag stays 1 with we low.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the pipelined register file.
// DATA_W_DEF / NUM_REGS_DEF : default datapath width and register count
// PC_IDX / PC_STEP          : register that doubles as the PC and its increment
// FLAG_C / FLAG_Z           : bit positions of the flags in the flag scoreboard
package rf_pkg;
  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 8;
  localparam int PC_IDX       = 7;
  localparam int PC_STEP      = 1;
  localparam int FLAG_C       = 0;
  localparam int FLAG_Z       = 1;
  localparam int NUM_FLAGS    = 2;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit vector for outstanding destination claims.
// clk, rst  : clock, async active-high reset (clears every bit)
// set_vec   : bits to claim at the next edge
// clr_vec   : bits released at the next edge (a writeback landed)
// lk_idx    : packed lookup indices, lookup k at [k*IDX_W +: IDX_W]
// lk_mask   : lookup k is being written this cycle, so its hazard is already resolved
// lk_busy   : busy bit at lk_idx, suppressed by lk_mask
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int N      = 8,
  parameter int IDX_W  = 3,
  parameter int NUM_LK = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            set_vec,
  input  logic [N-1:0]            clr_vec,
  input  logic [NUM_LK*IDX_W-1:0] lk_idx,
  input  logic [NUM_LK-1:0]       lk_mask,
  output logic [NUM_LK-1:0]       lk_busy
);

  logic [N-1:0] busy_q;

  // Set is applied after clear so a claim racing a writeback on the same bit survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= (busy_q & ~clr_vec) | set_vec;
  end

  for (genvar k = 0; k < NUM_LK; k++) begin : g_lk
    assign lk_busy[k] = busy_q[lk_idx[k*IDX_W +: IDX_W]] & ~lk_mask[k];
  end

endmodule

// File: rtl/pipelined_register_file.sv
// Register file for the pipelined IITB-RISC core: NUM_REGS GPRs (one is the PC),
// C/Z flags, NUM_RD bypassed combinational read ports, two write ports (B beats A),
// and busy scoreboards that drive the decode-stage stall.
// rd_addr/rd_data/rd_busy : packed read ports, port k in slice k
// wa_* / wb_*             : ALU and load writeback ports
// claim_*                 : issue-stage reservations of a GPR and/or the flags
// c_*/z_*                 : flag writes, bypassed flag values and flag busy
// pc_en/pc_new/pc_inc     : PC update controls, lower priority than a GPR write to PC_IDX
// pc_current              : registered PC (no bypass)
// stall                   : any read port touches a busy register
module pipelined_register_file
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int PC_IDX   = rf_pkg::PC_IDX,
  parameter int PC_STEP  = rf_pkg::PC_STEP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic                     claim_c,
  input  logic                     claim_z,
  input  logic                     c_we,
  input  logic                     z_we,
  input  logic                     c_data,
  input  logic                     z_data,
  output logic                     c_flag,
  output logic                     z_flag,
  output logic                     c_busy,
  output logic                     z_busy,
  input  logic                     pc_en,
  input  logic [DATA_W-1:0]        pc_new,
  input  logic                     pc_inc,
  output logic [DATA_W-1:0]        pc_current,
  output logic                     stall
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              c_q, z_q;

  // Register array. The PC lives in regs[PC_IDX]; a GPR write there outranks pc_en/pc_inc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_en && wb_addr == ADDR_W'(i))      regs[i] <= wb_data;
        else if (wa_en && wa_addr == ADDR_W'(i)) regs[i] <= wa_data;
        else if (i == PC_IDX) begin
          if (pc_en)       regs[i] <= pc_new;
          else if (pc_inc) regs[i] <= regs[i] + DATA_W'(PC_STEP);
        end
      end
      if (c_we) c_q <= c_data;
      if (z_we) z_q <= z_data;
    end
  end

  assign pc_current = regs[PC_IDX];
  assign c_flag     = c_we ? c_data : c_q;
  assign z_flag     = z_we ? z_data : z_q;

  // Read ports: B bypass, then A bypass, then array. A bypassing write also hides the hazard.
  logic [NUM_RD-1:0] rd_mask;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit_a, hit_b;
    assign addr  = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit_b = wb_en && (wb_addr == addr);
    assign hit_a = wa_en && (wa_addr == addr);
    assign rd_data[k*DATA_W +: DATA_W] = hit_b ? wb_data : (hit_a ? wa_data : regs[addr]);
    assign rd_mask[k] = hit_a | hit_b;
  end

  logic [NUM_REGS-1:0] reg_set, reg_clr;
  always_comb begin
    reg_set = '0;
    reg_clr = '0;
    if (claim_en) reg_set[claim_addr] = 1'b1;
    if (wa_en)    reg_clr[wa_addr]    = 1'b1;
    if (wb_en)    reg_clr[wb_addr]    = 1'b1;
  end

  rf_scoreboard #(.N(NUM_REGS), .IDX_W(ADDR_W), .NUM_LK(NUM_RD)) u_reg_sb (
    .clk     (clk),
    .rst     (rst),
    .set_vec (reg_set),
    .clr_vec (reg_clr),
    .lk_idx  (rd_addr),
    .lk_mask (rd_mask),
    .lk_busy (rd_busy)
  );

  logic [NUM_FLAGS-1:0] flag_set, flag_clr, flag_mask, flag_busy;
  logic [NUM_FLAGS-1:0] flag_idx;

  assign flag_set[FLAG_C]  = claim_c;
  assign flag_set[FLAG_Z]  = claim_z;
  assign flag_clr[FLAG_C]  = c_we;
  assign flag_clr[FLAG_Z]  = z_we;
  assign flag_mask[FLAG_C] = c_we;
  assign flag_mask[FLAG_Z] = z_we;
  // Lookup k simply reads flag bit k.
  assign flag_idx[FLAG_C]  = 1'(FLAG_C);
  assign flag_idx[FLAG_Z]  = 1'(FLAG_Z);

  rf_scoreboard #(.N(NUM_FLAGS), .IDX_W(1), .NUM_LK(NUM_FLAGS)) u_flag_sb (
    .clk     (clk),
    .rst     (rst),
    .set_vec (flag_set),
    .clr_vec (flag_clr),
    .lk_idx  (flag_idx),
    .lk_mask (flag_mask),
    .lk_busy (flag_busy)
  );

  assign c_busy = flag_busy[FLAG_C];
  assign z_busy = flag_busy[FLAG_Z];
  assign stall  = |rd_busy;

endmodule

// File: tb/tb_pipelined_register_file.sv
module tb_pipelined_register_file;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 3;
  localparam int RD = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [RD*AW-1:0] rd_addr;
  logic [RD*DW-1:0] rd_data;
  logic [RD-1:0]  rd_busy;
  logic           wa_en, wb_en, claim_en, claim_c, claim_z;
  logic [AW-1:0]  wa_addr, wb_addr, claim_addr;
  logic [DW-1:0]  wa_data, wb_data, pc_new, pc_current;
  logic           c_we, z_we, c_data, z_data, c_flag, z_flag, c_busy, z_busy;
  logic           pc_en, pc_inc, stall;

  int checks = 0;
  int errors = 0;
  logic cmp_on = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  pipelined_register_file dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_c(claim_c), .claim_z(claim_z),
    .c_we(c_we), .z_we(z_we), .c_data(c_data), .z_data(z_data),
    .c_flag(c_flag), .z_flag(z_flag), .c_busy(c_busy), .z_busy(z_busy),
    .pc_en(pc_en), .pc_new(pc_new), .pc_inc(pc_inc), .pc_current(pc_current), .stall(stall)
  );

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_regs [NR];
  logic          m_busy [NR];
  logic          m_c, m_z, m_cb, m_zb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
      m_c = 1'b0; m_z = 1'b0; m_cb = 1'b0; m_zb = 1'b0;
    end else begin
      // PC side effects only when no GPR write targets the PC this edge
      if (!((wa_en && wa_addr == 3'd7) || (wb_en && wb_addr == 3'd7))) begin
        if (pc_en)       m_regs[7] = pc_new;
        else if (pc_inc) m_regs[7] = m_regs[7] + 16'd1;
      end
      if (wa_en) begin m_regs[wa_addr] = wa_data; m_busy[wa_addr] = 1'b0; end
      if (wb_en) begin m_regs[wb_addr] = wb_data; m_busy[wb_addr] = 1'b0; end
      if (claim_en) m_busy[claim_addr] = 1'b1;
      if (c_we) begin m_c = c_data; m_cb = 1'b0; end
      if (z_we) begin m_z = z_data; m_zb = 1'b0; end
      if (claim_c) m_cb = 1'b1;
      if (claim_z) m_zb = 1'b1;
    end
  end

  function automatic logic written_now(input logic [AW-1:0] a);
    return (wa_en && wa_addr == a) || (wb_en && wb_addr == a);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (wb_en && wb_addr == a) return wb_data;
    if (wa_en && wa_addr == a) return wa_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return m_busy[a] && !written_now(a);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      logic exp_stall;
      exp_stall = 1'b0;
      for (int k = 0; k < RD; k++) begin
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        chk($sformatf("m_rd_data%0d", k), 32'(rd_data[k*DW +: DW]), 32'(exp_rd(a)));
        chk($sformatf("m_rd_busy%0d", k), 32'(rd_busy[k]), 32'(exp_busy(a)));
        exp_stall = exp_stall | exp_busy(a);
      end
      chk("m_stall", 32'(stall), 32'(exp_stall));
      chk("m_pc", 32'(pc_current), 32'(m_regs[7]));
      chk("m_c_flag", 32'(c_flag), 32'(c_we ? c_data : m_c));
      chk("m_z_flag", 32'(z_flag), 32'(z_we ? z_data : m_z));
      chk("m_c_busy", 32'(c_busy), 32'(m_cb && !c_we));
      chk("m_z_busy", 32'(z_busy), 32'(m_zb && !z_we));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    wa_en = 0; wa_addr = 0; wa_data = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    claim_en = 0; claim_addr = 0; claim_c = 0; claim_z = 0;
    c_we = 0; z_we = 0; c_data = 0; z_data = 0;
    pc_en = 0; pc_new = 0; pc_inc = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wa_en = 1; wa_addr = a; wa_data = d;
  endtask

  task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    set_rd(3'd0, 3'd7);
    rst = 1'b1;
    #3;
    chk("rst_rd0", 32'(rd_data[15:0]), 32'h0);
    chk("rst_rd1", 32'(rd_data[31:16]), 32'h0);
    chk("rst_pc", 32'(pc_current), 32'h0);
    chk("rst_flags", 32'({c_flag, z_flag, c_busy, z_busy}), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    step();
    rst = 1'b0;
    cmp_on = 1'b1;

    // independent writes on both ports
    wr_a(3'd1, 16'h1234); wr_b(3'd4, 16'hBEEF); set_rd(3'd1, 3'd4);
    #2;
    chk("byp_r1", 32'(rd_data[15:0]), 32'h1234);
    chk("byp_r4", 32'(rd_data[31:16]), 32'hBEEF);
    step(); idle(); #2;
    chk("arr_r1", 32'(rd_data[15:0]), 32'h1234);
    chk("arr_r4", 32'(rd_data[31:16]), 32'hBEEF);

    // dual-write collision: port B wins
    wr_a(3'd3, 16'h1111); wr_b(3'd3, 16'h2222); set_rd(3'd3, 3'd0);
    #2 chk("coll_byp", 32'(rd_data[15:0]), 32'h2222);
    step(); idle(); #2;
    chk("coll_arr", 32'(rd_data[15:0]), 32'h2222);

    // hazard then same-cycle writeback resolves it
    claim_en = 1; claim_addr = 3'd2; set_rd(3'd2, 3'd1);
    #2 chk("haz_c0_busy", 32'(rd_busy), 32'h0);
    step(); idle(); #2;
    chk("haz_c1_busy", 32'(rd_busy), 32'h1);
    chk("haz_c1_stall", 32'(stall), 32'h1);
    step();
    wr_a(3'd2, 16'h00AB);
    #2;
    chk("haz_c2_busy", 32'(rd_busy), 32'h0);
    chk("haz_c2_data", 32'(rd_data[15:0]), 32'h00AB);
    chk("haz_c2_stall", 32'(stall), 32'h0);
    step(); idle(); #2;
    chk("haz_c3_busy", 32'(rd_busy), 32'h0);

    // claim racing a write of the same register: claim wins
    claim_en = 1; claim_addr = 3'd5; wr_b(3'd5, 16'h5555);
    step(); idle(); set_rd(3'd5, 3'd5); #2;
    chk("race_data", 32'(rd_data[15:0]), 32'h5555);
    chk("race_busy", 32'(rd_busy), 32'h3);
    chk("race_stall", 32'(stall), 32'h1);
    step();
    wr_a(3'd5, 16'h0005);
    step(); idle();

    // PC priority
    pc_en = 1; pc_new = 16'hFFFF;
    step(); idle(); #2 chk("pc_load", 32'(pc_current), 32'hFFFF);
    pc_inc = 1;
    step(); idle(); #2 chk("pc_wrap", 32'(pc_current), 32'h0000);
    pc_en = 1; pc_new = 16'h0040; wr_a(3'd7, 16'h0100); set_rd(3'd7, 3'd0);
    #2;
    chk("pc_rd_byp", 32'(rd_data[15:0]), 32'h0100);
    chk("pc_no_byp", 32'(pc_current), 32'h0000);
    step(); idle(); #2 chk("pc_gpr_wins", 32'(pc_current), 32'h0100);
    pc_en = 1; pc_new = 16'h0040;
    step(); idle(); #2 chk("pc_en", 32'(pc_current), 32'h0040);
    pc_inc = 1; wr_b(3'd7, 16'h0200);
    step(); idle(); #2 chk("pc_wb_over_inc", 32'(pc_current), 32'h0200);
    pc_inc = 1;
    step(); idle(); #2 chk("pc_inc", 32'(pc_current), 32'h0201);

    // flags
    claim_c = 1;
    step(); idle(); #2 chk("c_claimed", 32'(c_busy), 32'h1);
    c_we = 1; c_data = 1;
    #2;
    chk("c_byp", 32'(c_flag), 32'h1);
    chk("c_busy_mask", 32'(c_busy), 32'h0);
    step(); idle(); #2;
    chk("c_hold", 32'(c_flag), 32'h1);
    chk("c_busy_clr", 32'(c_busy), 32'h0);
    claim_z = 1; z_we = 1; z_data = 1;
    step(); idle(); #2;
    chk("z_set", 32'(z_flag), 32'h1);
    chk("z_race_busy", 32'(z_busy), 32'h1);
    z_we = 1; z_data = 0;
    #2 chk("z_byp_clr", 32'({z_flag, z_busy}), 32'h0);
    step(); idle();

    // fill every register through alternating ports, then read pairs back
    for (int i = 0; i < NR; i++) begin
      if (i % 2 == 0) wr_a(AW'(i), 16'h1000 + 16'(i * 'h11));
      else            wr_b(AW'(i), 16'h1000 + 16'(i * 'h11));
      step(); idle();
    end
    for (int i = 0; i < NR; i += 2) begin
      set_rd(AW'(i), AW'(i + 1));
      step();
    end
    set_rd(3'd6, 3'd3); #2;
    chk("fill_r6", 32'(rd_data[15:0]), 32'h1066);
    chk("fill_r3", 32'(rd_data[31:16]), 32'h1033);

    // asynchronous reset mid-run discards claims and clears state without a clock edge
    step();
    claim_en = 1; claim_addr = 3'd6; c_we = 1; c_data = 1;
    step(); idle(); #2;
    chk("pre_rst_stall", 32'(stall), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_rd0", 32'(rd_data[15:0]), 32'h0);
    chk("arst_rd1", 32'(rd_data[31:16]), 32'h0);
    chk("arst_pc", 32'(pc_current), 32'h0);
    chk("arst_flags", 32'({c_flag, z_flag}), 32'h0);
    chk("arst_stall", 32'(stall), 32'h0);
    step();
    rst = 1'b0;
    step(); #2;
    chk("post_rst_busy", 32'(rd_busy), 32'h0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
